// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared types and constants for the FPU issue controller: rounding modes,
// field widths, exception flag positions and the controller state encoding.
package fpu_issue_ctrl_pkg;

  localparam int unsigned RM_W     = 3;
  localparam int unsigned OPT_W    = 5;
  localparam int unsigned RD_W     = 5;
  localparam int unsigned FFLAGS_W = 5;
  localparam int unsigned FCSR_W   = RM_W + FFLAGS_W;

  // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100,
    RM_DYN = 3'b111
  } rm_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Pipeline request, FPU start/ready, writeback and fcsr signals of the issue controller.
// The master modport is the controller's view; slave is the surrounding pipeline/FPU.
interface fpu_issue_ctrl_if #(parameter int unsigned XLEN = 32);
  import fpu_issue_ctrl_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [OPT_W-1:0]    req_option;
  logic [RM_W-1:0]     req_rm;
  logic [RD_W-1:0]     req_rd;
  logic [XLEN-1:0]     req_in1, req_in2, req_in3;

  logic                fpu_start;
  logic [RM_W-1:0]     fpu_rm;
  logic [OPT_W-1:0]    fpu_option;
  logic [XLEN-1:0]     fpu_in1, fpu_in2, fpu_in3;
  logic                fpu_ready;
  logic [XLEN-1:0]     fpu_out;
  logic                fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [RD_W-1:0]     rsp_rd;
  logic [XLEN-1:0]     rsp_data;
  logic [FFLAGS_W-1:0] rsp_fflags;
  logic                rsp_illegal;
  logic                rsp_timeout;

  logic                csr_we;
  logic [FCSR_W-1:0]   csr_wdata;
  logic [FCSR_W-1:0]   fcsr;

  modport master (
    input  req_valid, req_option, req_rm, req_rd, req_in1, req_in2, req_in3,
           fpu_ready, fpu_out, fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx,
           rsp_ready, csr_we, csr_wdata,
    output req_ready, fpu_start, fpu_rm, fpu_option, fpu_in1, fpu_in2, fpu_in3,
           rsp_valid, rsp_rd, rsp_data, rsp_fflags, rsp_illegal, rsp_timeout, fcsr
  );

  modport slave (
    output req_valid, req_option, req_rm, req_rd, req_in1, req_in2, req_in3,
           fpu_ready, fpu_out, fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx,
           rsp_ready, csr_we, csr_wdata,
    input  req_ready, fpu_start, fpu_rm, fpu_option, fpu_in1, fpu_in2, fpu_in3,
           rsp_valid, rsp_rd, rsp_data, rsp_fflags, rsp_illegal, rsp_timeout, fcsr
  );

endinterface

// File: rtl/fpu_rm_resolve.sv
// Resolves the instruction rounding mode against frm and flags reserved results.
module fpu_rm_resolve
  import fpu_issue_ctrl_pkg::*;
(
  input  logic [RM_W-1:0] req_rm,
  input  logic [RM_W-1:0] frm,
  output logic [RM_W-1:0] rm_res,
  output logic            illegal
);

  always_comb begin
    rm_res  = (req_rm == RM_DYN) ? frm : req_rm;
    illegal = (rm_res > RM_RMM);
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: accepts one op, holds start until FPU ready, returns result
// and accumulates sticky fflags. Optional BUSY watchdog enabled by FPU_TIMEOUT_EN.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
`ifdef FPU_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic               clk,
  input  logic               rst,
  fpu_issue_ctrl_if.master   bus
);

`ifdef FPU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt, cnt_nxt;
`endif

  state_e              state, state_nxt;
  logic [RM_W-1:0]     rm_res;
  logic                illegal;
  logic [FFLAGS_W-1:0] op_flags, fflags_base;

  logic                ready, ready_nxt, start, start_nxt, valid, valid_nxt;
  logic [RM_W-1:0]     rm, rm_nxt, frm, frm_nxt;
  logic [OPT_W-1:0]    option, option_nxt;
  logic [XLEN-1:0]     in1, in1_nxt, in2, in2_nxt, in3, in3_nxt;
  logic [RD_W-1:0]     rd, rd_nxt;
  logic [XLEN-1:0]     data, data_nxt;
  logic [FFLAGS_W-1:0] flags, flags_nxt, fflags, fflags_nxt;
  logic                ill, ill_nxt, tmo, tmo_nxt;

  fpu_rm_resolve u_rm_resolve (
    .req_rm  (bus.req_rm),
    .frm     (frm),
    .rm_res  (rm_res),
    .illegal (illegal)
  );

  always_comb begin
    op_flags          = '0;
    op_flags[FLAG_NV] = bus.fpu_nv;
    op_flags[FLAG_DZ] = bus.fpu_dz;
    op_flags[FLAG_OF] = bus.fpu_of;
    op_flags[FLAG_UF] = bus.fpu_uf;
    op_flags[FLAG_NX] = bus.fpu_nx;
  end

  // Next-state and next register values; every output is a register fed from here
  always_comb begin
    state_nxt   = state;
    rm_nxt      = rm;
    option_nxt  = option;
    in1_nxt     = in1;
    in2_nxt     = in2;
    in3_nxt     = in3;
    rd_nxt      = rd;
    data_nxt    = data;
    flags_nxt   = flags;
    ill_nxt     = ill;
    tmo_nxt     = 1'b0;
    frm_nxt     = bus.csr_we ? bus.csr_wdata[FCSR_W-1:FFLAGS_W] : frm;
    fflags_base = bus.csr_we ? bus.csr_wdata[FFLAGS_W-1:0] : fflags;
    fflags_nxt  = fflags_base;
`ifdef FPU_TIMEOUT_EN
    cnt_nxt     = cnt;
    tmo_nxt     = tmo;
`endif

    unique case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          rm_nxt     = rm_res;
          option_nxt = bus.req_option;
          in1_nxt    = bus.req_in1;
          in2_nxt    = bus.req_in2;
          in3_nxt    = bus.req_in3;
          rd_nxt     = bus.req_rd;
          tmo_nxt    = 1'b0;
          if (illegal) begin
            state_nxt = ST_DONE;
            ill_nxt   = 1'b1;
            data_nxt  = '0;
            flags_nxt = '0;
          end else begin
            state_nxt = ST_BUSY;
            ill_nxt   = 1'b0;
`ifdef FPU_TIMEOUT_EN
            cnt_nxt   = '0;
`endif
          end
        end
      end
      ST_BUSY: begin
        if (bus.fpu_ready) begin
          state_nxt  = ST_DONE;
          data_nxt   = bus.fpu_out;
          flags_nxt  = op_flags;
          fflags_nxt = fflags_base | op_flags;
        end
`ifdef FPU_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt           = ST_DONE;
          data_nxt            = XLEN'(CANON_NAN);
          flags_nxt           = '0;
          flags_nxt[FLAG_NV]  = 1'b1;
          fflags_nxt          = fflags_base;
          fflags_nxt[FLAG_NV] = 1'b1;
          tmo_nxt             = 1'b1;
        end else begin
          cnt_nxt = CNT_W'(cnt + 1'b1);
        end
`endif
      end
      ST_DONE: begin
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    ready_nxt = (state_nxt == ST_IDLE);
    start_nxt = (state_nxt == ST_BUSY);
    valid_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      ready  <= 1'b1;
      start  <= 1'b0;
      valid  <= 1'b0;
      rm     <= '0;
      frm    <= '0;
      option <= '0;
      in1    <= '0;
      in2    <= '0;
      in3    <= '0;
      rd     <= '0;
      data   <= '0;
      flags  <= '0;
      fflags <= '0;
      ill    <= 1'b0;
      tmo    <= 1'b0;
`ifdef FPU_TIMEOUT_EN
      cnt    <= '0;
`endif
    end else begin
      state  <= state_nxt;
      ready  <= ready_nxt;
      start  <= start_nxt;
      valid  <= valid_nxt;
      rm     <= rm_nxt;
      frm    <= frm_nxt;
      option <= option_nxt;
      in1    <= in1_nxt;
      in2    <= in2_nxt;
      in3    <= in3_nxt;
      rd     <= rd_nxt;
      data   <= data_nxt;
      flags  <= flags_nxt;
      fflags <= fflags_nxt;
      ill    <= ill_nxt;
      tmo    <= tmo_nxt;
`ifdef FPU_TIMEOUT_EN
      cnt    <= cnt_nxt;
`endif
    end
  end

  assign bus.req_ready   = ready;
  assign bus.fpu_start   = start;
  assign bus.fpu_rm      = rm;
  assign bus.fpu_option  = option;
  assign bus.fpu_in1     = in1;
  assign bus.fpu_in2     = in2;
  assign bus.fpu_in3     = in3;
  assign bus.rsp_valid   = valid;
  assign bus.rsp_rd      = rd;
  assign bus.rsp_data    = data;
  assign bus.rsp_fflags  = flags;
  assign bus.rsp_illegal = ill;
  assign bus.rsp_timeout = tmo;
  assign bus.fcsr        = {frm, fflags};

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed scenarios plus randomized ops
// against a transaction-level fcsr/rounding model. Honours FPU_TIMEOUT_EN.
module tb_fpu_issue_ctrl;

  localparam int BUDGET = 200;

  typedef struct {
    int          start_cycles;
    int          latency;
    bit          got_rsp;
    bit          stable_ops;
    bit          start_after;
    bit          hold_ok;
    bit          idle_after;
    logic [2:0]  rm;
    logic [4:0]  opt;
    logic [31:0] in1, in2, in3;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  fflags;
    logic        illegal, timeout;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] m_frm;
  logic [4:0] m_fflags;

  always #5 clk = ~clk;

  fpu_issue_ctrl_if #(.XLEN(32)) bus ();

  fpu_issue_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [7:0] v);
    bus.csr_we    = 1'b1;
    bus.csr_wdata = v;
    tick();
    bus.csr_we    = 1'b0;
    m_frm         = v[7:5];
    m_fflags      = v[4:0];
  endtask

  // Reference: rm resolution at accept, then sticky flag accumulation at completion
  task automatic model_op(input logic [2:0] rm, input logic [4:0] flg, input bit cap,
                          input logic [7:0] cv, output logic [2:0] rm_res, output bit ill);
    rm_res = (rm == 3'b111) ? m_frm : rm;
    ill    = (rm_res > 3'd4);
    if (!ill) begin
      if (cap) begin
        m_frm    = cv[7:5];
        m_fflags = cv[4:0] | flg;
      end else begin
        m_fflags = m_fflags | flg;
      end
    end
  endtask

  // Drives one op end to end; lat = BUSY cycle index where FPU ready is raised (-1: never)
  task automatic do_op(input logic [4:0] opt, input logic [2:0] rm, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input int lat, input logic [31:0] res, input logic [4:0] flg,
                       input int hold, input bit cap, input logic [7:0] cv, output obs_t o);
    o = '{default: 0};
    bus.req_valid = 1'b1; bus.req_option = opt; bus.req_rm = rm; bus.req_rd = rd;
    bus.req_in1 = a; bus.req_in2 = b; bus.req_in3 = c;
    tick();
    bus.req_valid = 1'b0; bus.req_option = 5'($urandom); bus.req_rm = 3'($urandom);
    bus.req_rd = 5'($urandom); bus.req_in1 = $urandom; bus.req_in2 = $urandom; bus.req_in3 = $urandom;
    o.latency = 1;
    o.stable_ops = 1'b1;
    o.rm = bus.fpu_rm; o.opt = bus.fpu_option;
    o.in1 = bus.fpu_in1; o.in2 = bus.fpu_in2; o.in3 = bus.fpu_in3;
    for (int k = 0; k < BUDGET && !bus.rsp_valid; k++) begin
      if (bus.fpu_start) begin
        o.start_cycles++;
        if ({bus.fpu_rm, bus.fpu_option, bus.fpu_in1, bus.fpu_in2, bus.fpu_in3} !==
            {o.rm, o.opt, o.in1, o.in2, o.in3}) o.stable_ops = 1'b0;
      end
      if (k == lat) begin
        bus.fpu_ready = 1'b1;
        bus.fpu_out = res;
        {bus.fpu_nv, bus.fpu_dz, bus.fpu_of, bus.fpu_uf, bus.fpu_nx} = flg;
        if (cap) begin
          bus.csr_we = 1'b1;
          bus.csr_wdata = cv;
        end
      end
      tick();
      bus.fpu_ready = 1'b0;
      bus.csr_we = 1'b0;
      bus.fpu_out = $urandom;
      {bus.fpu_nv, bus.fpu_dz, bus.fpu_of, bus.fpu_uf, bus.fpu_nx} = 5'($urandom);
      o.latency++;
    end
    o.got_rsp = bus.rsp_valid;
    if (!o.got_rsp) return;
    o.start_after = bus.fpu_start;
    o.rd = bus.rsp_rd; o.data = bus.rsp_data; o.fflags = bus.rsp_fflags;
    o.illegal = bus.rsp_illegal; o.timeout = bus.rsp_timeout;
    o.hold_ok = !bus.req_ready;
    for (int h = 0; h < hold; h++) begin
      bus.fpu_ready = (h == 1);
      tick();
      bus.fpu_ready = 1'b0;
      if (!bus.rsp_valid || bus.req_ready || bus.rsp_data !== o.data || bus.rsp_fflags !== o.fflags ||
          bus.rsp_rd !== o.rd || bus.rsp_illegal !== o.illegal) o.hold_ok = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    o.idle_after = bus.req_ready && !bus.rsp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    m_frm = 3'd0; m_fflags = 5'd0;
    checks++;
    if ({bus.req_ready, bus.fpu_start, bus.rsp_valid} !== 3'b100) begin
      errors++; $display("FAIL reset_ctrl: ready/start/valid=%b expected 100",
                         {bus.req_ready, bus.fpu_start, bus.rsp_valid});
    end
    checks++;
    if ({bus.fcsr, bus.fpu_rm, bus.rsp_data, bus.rsp_fflags, bus.rsp_illegal, bus.rsp_timeout} !== '0) begin
      errors++; $display("FAIL reset_regs: fcsr=%h fpu_rm=%h rsp_data=%h expected all zero",
                         bus.fcsr, bus.fpu_rm, bus.rsp_data);
    end
  endtask

  task automatic test_basic();
    obs_t o;
    do_op(5'b0_01_00, 3'b000, 5'd3, 32'h1, 32'h2, 32'h3, 3, 32'h3F80_0000, 5'b00001, 0, 1'b0, 8'h0, o);
    m_fflags = m_fflags | 5'b00001;
    checks++;
    if (o.data !== 32'h3F80_0000 || o.fflags !== 5'b00001) begin
      errors++; $display("FAIL basic_rsp: data=%h fflags=%b expected 3f800000 00001", o.data, o.fflags);
    end
    checks++;
    if (bus.fcsr[4:0] !== 5'b00001) begin
      errors++; $display("FAIL basic_fcsr: fcsr=%b expected flags 00001", bus.fcsr);
    end
    checks++;
    if (o.latency !== 5 || o.start_cycles !== 4 || o.start_after !== 1'b0) begin
      errors++; $display("FAIL basic_timing: latency=%0d start_cycles=%0d start_after=%0b expected 5 4 0",
                         o.latency, o.start_cycles, o.start_after);
    end
    checks++;
    if (o.rm !== 3'b000 || o.opt !== 5'b0_01_00 || o.rd !== 5'd3 || o.in3 !== 32'h3 || !o.stable_ops) begin
      errors++; $display("FAIL basic_issue: rm=%b opt=%b rd=%0d in3=%h stable=%0b expected 000 00100 3 3 1",
                         o.rm, o.opt, o.rd, o.in3, o.stable_ops);
    end
  endtask

  task automatic test_dyn_rm();
    obs_t o;
    csr_write(8'h60);
    do_op(5'd1, 3'b111, 5'd4, 32'h10, 32'h20, 32'h30, 1, 32'h4000_0000, 5'b0, 0, 1'b0, 8'h0, o);
    checks++;
    if (o.rm !== 3'b011 || o.start_cycles !== 2) begin
      errors++; $display("FAIL dyn_rm: fpu_rm=%b start_cycles=%0d expected 011 2", o.rm, o.start_cycles);
    end
    csr_write(8'hA0);
    do_op(5'd1, 3'b111, 5'd5, 32'h10, 32'h20, 32'h30, 0, 32'h4000_0000, 5'b11111, 0, 1'b0, 8'h0, o);
    checks++;
    if (o.illegal !== 1'b1 || o.start_cycles !== 0 || o.data !== 32'h0 || o.fflags !== 5'b0 || o.latency !== 1) begin
      errors++; $display("FAIL illegal_rm: illegal=%0b start_cycles=%0d data=%h fflags=%b latency=%0d expected 1 0 0 0 1",
                         o.illegal, o.start_cycles, o.data, o.fflags, o.latency);
    end
    checks++;
    if (bus.fcsr !== 8'hA0) begin
      errors++; $display("FAIL illegal_fcsr: fcsr=%h expected a0", bus.fcsr);
    end
  endtask

  task automatic test_sticky();
    obs_t o;
    csr_write(8'h00);
    do_op(5'd2, 3'b001, 5'd6, 32'h5, 32'h6, 32'h7, 0, 32'h7FC0_0000, 5'b10000, 0, 1'b0, 8'h0, o);
    do_op(5'd3, 3'b010, 5'd7, 32'h5, 32'h6, 32'h7, 2, 32'h7F80_0000, 5'b01000, 0, 1'b0, 8'h0, o);
    checks++;
    if (bus.fcsr[4:0] !== 5'b11000) begin
      errors++; $display("FAIL sticky_flags: fcsr=%b expected flags 11000", bus.fcsr);
    end
    do_op(5'd4, 3'b000, 5'd8, 32'h5, 32'h6, 32'h7, 1, 32'h1234_5678, 5'b00001, 0, 1'b1, 8'h00, o);
    checks++;
    if (bus.fcsr !== 8'b000_00001 || o.fflags !== 5'b00001) begin
      errors++; $display("FAIL csr_capture: fcsr=%b rsp_fflags=%b expected 00000001 00001", bus.fcsr, o.fflags);
    end
    m_frm = 3'd0; m_fflags = 5'b00001;
  endtask

  task automatic test_backpressure();
    obs_t o;
    do_op(5'd5, 3'b100, 5'd9, 32'hA, 32'hB, 32'hC, 0, 32'hCAFE_F00D, 5'b00010, 5, 1'b0, 8'h0, o);
    m_fflags = m_fflags | 5'b00010;
    checks++;
    if (o.data !== 32'hCAFE_F00D || o.rd !== 5'd9 || o.latency !== 2) begin
      errors++; $display("FAIL bp_rsp: data=%h rd=%0d latency=%0d expected cafef00d 9 2", o.data, o.rd, o.latency);
    end
    checks++;
    if (!o.hold_ok || !o.idle_after) begin
      errors++; $display("FAIL bp_hold: hold_ok=%0b idle_after=%0b expected 1 1", o.hold_ok, o.idle_after);
    end
    checks++;
    if (bus.fcsr !== {m_frm, m_fflags}) begin
      errors++; $display("FAIL bp_fcsr: fcsr=%h expected %h", bus.fcsr, {m_frm, m_fflags});
    end
  endtask

  task automatic test_timeout();
    obs_t o;
`ifdef FPU_TIMEOUT_EN
    do_op(5'd6, 3'b000, 5'd10, 32'h1, 32'h1, 32'h1, -1, 32'h0, 5'b0, 0, 1'b0, 8'h0, o);
    m_fflags = m_fflags | 5'b10000;
    checks++;
    if (o.timeout !== 1'b1 || o.data !== 32'h7FC0_0000 || o.fflags !== 5'b10000 || o.start_cycles !== 64) begin
      errors++; $display("FAIL timeout_rsp: timeout=%0b data=%h fflags=%b start_cycles=%0d expected 1 7fc00000 10000 64",
                         o.timeout, o.data, o.fflags, o.start_cycles);
    end
`else
    do_op(5'd6, 3'b000, 5'd10, 32'h1, 32'h1, 32'h1, 100, 32'h5555_AAAA, 5'b00100, 0, 1'b0, 8'h0, o);
    m_fflags = m_fflags | 5'b00100;
    checks++;
    if (o.timeout !== 1'b0 || o.data !== 32'h5555_AAAA || o.start_cycles !== 101) begin
      errors++; $display("FAIL long_busy: timeout=%0b data=%h start_cycles=%0d expected 0 5555aaaa 101",
                         o.timeout, o.data, o.start_cycles);
    end
`endif
    checks++;
    if (bus.fcsr !== {m_frm, m_fflags} || !o.idle_after) begin
      errors++; $display("FAIL timeout_fcsr: fcsr=%h idle=%0b expected %h 1", bus.fcsr, o.idle_after, {m_frm, m_fflags});
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [4:0] opt, rd, flg;
    logic [2:0] rm, exp_rm;
    logic [31:0] a, b, c, res;
    logic [7:0] cv;
    int lat, hold;
    bit cap, ill;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: csr_write(8'($urandom));
        1: begin
          bus.fpu_ready = 1'b1;
          {bus.fpu_nv, bus.fpu_dz, bus.fpu_of, bus.fpu_uf, bus.fpu_nx} = 5'($urandom);
          tick();
          bus.fpu_ready = 1'b0;
        end
        default: ;
      endcase
      opt = 5'($urandom); rm = 3'($urandom); rd = 5'($urandom);
      a = $urandom; b = $urandom; c = $urandom; res = $urandom; flg = 5'($urandom);
      lat = $urandom_range(0, 6); hold = $urandom_range(0, 3);
      cap = ($urandom_range(0, 4) == 0); cv = 8'($urandom);
      model_op(rm, flg, cap, cv, exp_rm, ill);
      do_op(opt, rm, rd, a, b, c, lat, res, flg, hold, cap, cv, o);
      checks++;
      if (!o.got_rsp || o.illegal !== ill || o.timeout !== 1'b0 || o.rd !== rd) begin
        errors++; $display("FAIL rnd_status[%0d]: got=%0b illegal=%0b timeout=%0b rd=%0d expected 1 %0b 0 %0d",
                           n, o.got_rsp, o.illegal, o.timeout, o.rd, ill, rd);
      end
      checks++;
      if (o.data !== (ill ? 32'h0 : res) || o.fflags !== (ill ? 5'b0 : flg)) begin
        errors++; $display("FAIL rnd_result[%0d]: data=%h fflags=%b expected %h %b",
                           n, o.data, o.fflags, ill ? 32'h0 : res, ill ? 5'b0 : flg);
      end
      checks++;
      if (o.start_cycles !== (ill ? 0 : lat + 1) || o.latency !== (ill ? 1 : lat + 2) || o.start_after) begin
        errors++; $display("FAIL rnd_timing[%0d]: start_cycles=%0d latency=%0d expected %0d %0d",
                           n, o.start_cycles, o.latency, ill ? 0 : lat + 1, ill ? 1 : lat + 2);
      end
      if (!ill) begin
        checks++;
        if (o.rm !== exp_rm || o.opt !== opt || o.in1 !== a || o.in2 !== b || o.in3 !== c || !o.stable_ops) begin
          errors++; $display("FAIL rnd_issue[%0d]: rm=%b opt=%h in1=%h stable=%0b expected %b %h %h 1",
                             n, o.rm, o.opt, o.in1, o.stable_ops, exp_rm, opt, a);
        end
      end
      checks++;
      if (!o.hold_ok || !o.idle_after || bus.fcsr !== {m_frm, m_fflags}) begin
        errors++; $display("FAIL rnd_wb[%0d]: hold_ok=%0b idle=%0b fcsr=%h expected 1 1 %h",
                           n, o.hold_ok, o.idle_after, bus.fcsr, {m_frm, m_fflags});
      end
    end
  endtask

  task automatic test_reset_mid();
    bit late;
    csr_write(8'h3F);
    bus.req_valid = 1'b1; bus.req_rm = 3'b000; bus.req_option = 5'd1; bus.req_rd = 5'd2;
    tick();
    bus.req_valid = 1'b0;
    tick();
    checks++;
    if (bus.fpu_start !== 1'b1) begin
      errors++; $display("FAIL mid_busy: fpu_start=%0b expected 1", bus.fpu_start);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_frm = 3'd0; m_fflags = 5'd0;
    checks++;
    if ({bus.fpu_start, bus.rsp_valid, bus.req_ready} !== 3'b001 || bus.fcsr !== 8'h00) begin
      errors++; $display("FAIL mid_reset: start/valid/ready=%b fcsr=%h expected 001 00",
                         {bus.fpu_start, bus.rsp_valid, bus.req_ready}, bus.fcsr);
    end
    bus.fpu_ready = 1'b1; bus.fpu_out = 32'hDEAD_BEEF;
    {bus.fpu_nv, bus.fpu_dz, bus.fpu_of, bus.fpu_uf, bus.fpu_nx} = 5'b11111;
    late = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.fpu_ready = 1'b0;
      if (bus.rsp_valid || bus.fpu_start) late = 1'b1;
    end
    checks++;
    if (late || bus.fcsr !== 8'h00) begin
      errors++; $display("FAIL late_rsp: late=%0b fcsr=%h expected 0 00", late, bus.fcsr);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_option = '0; bus.req_rm = '0; bus.req_rd = '0;
    bus.req_in1 = '0; bus.req_in2 = '0; bus.req_in3 = '0;
    bus.fpu_ready = 1'b0; bus.fpu_out = '0;
    {bus.fpu_nv, bus.fpu_dz, bus.fpu_of, bus.fpu_uf, bus.fpu_nx} = '0;
    bus.rsp_ready = 1'b0; bus.csr_we = 1'b0; bus.csr_wdata = '0;
    test_reset();
    test_basic();
    test_dyn_rm();
    test_sticky();
    test_backpressure();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
